// File: rtl/uart_pkg.sv
// Shared types and frame constants for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a registered-output FIFO and sends each as an 8N1-style UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DSIZE        = 8,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DSIZE-1:0] fifo_dout,
  output logic             tx,
  output logic             busy,
  output logic             byte_done
);

  localparam int unsigned BW = $clog2(DSIZE) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DSIZE - 1);

  tx_state_t        state_q, state_d;
  logic [DSIZE-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             tick;
  logic             baud_clear;

  assign baud_clear = (state_q != START) && (state_q != DATA) && (state_q != STOP);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clear(baud_clear),
    .tick (tick)
  );

  assign fifo_rd_en = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign byte_done  = (state_q == STOP) && tick;
  assign tx         = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      IDLE:  if (enable && !fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_dout;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d   = shift_q >> 1;
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == LAST_BIT) state_d = STOP;
      end
      STOP: if (tick) state_d = (enable && !fifo_empty) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from the next state to line up with it
    unique case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= STOP_BIT;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural registered-output FIFO.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout;
  logic       tx;
  logic       busy;
  logic       byte_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:15];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int rd_count = 0;
  int bd_count = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .rstn      (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial fifo_dout = '0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
      rd_count  <= rd_count + 1;
    end
    if (byte_done) bd_count <= bd_count + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (fifo_rd_en) chk("no_underflow_read", {31'b0, fifo_empty}, 32'd0);

  task automatic push(input logic [7:0] v);
    mem[wr_ptr % 16] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, {31'b0, tx}, 32'd0);
  endtask

  // Called on the negedge of start-bit cycle 1; returns on the negedge after cycle 40.
  task automatic check_frame(input logic [9:0] line, input string tag, input int drop_at);
    int cyc = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        cyc++;
        if (cyc == drop_at) enable = 1'b0;
        chk($sformatf("%s_b%0d_c%0d_tx", tag, b, c), {31'b0, tx}, {31'b0, line[b]});
        chk($sformatf("%s_b%0d_c%0d_bd", tag, b, c), {31'b0, byte_done},
            {31'b0, (b == 9 && c == 3)});
        chk($sformatf("%s_b%0d_c%0d_busy", tag, b, c), {31'b0, busy}, 32'd1);
        @(negedge clk);
      end
    end
  endtask

  // From the negedge after a stop bit: two high fetch/load cycles then the next start.
  task automatic check_gap(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_gap%0d_tx", tag, g), {31'b0, tx}, 32'd1);
      chk($sformatf("%s_gap%0d_busy", tag, g), {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int rd0, bd0;
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h3C, 10'b1_00111100_0};
    vecs[2] = '{8'h81, 10'b1_10000001_0};
    vecs[3] = '{8'h01, 10'b1_00000001_0};

    // Reset held in idle
    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      chk("rst_byte_done", {31'b0, byte_done}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_tx", {31'b0, tx}, 32'd1);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
    end

    // Single frames from the table
    for (int v = 0; v < 4; v++) begin
      rd0 = rd_count;
      bd0 = bd_count;
      push(vecs[v].data);
      enable = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_rd_en_latency", v), {31'b0, fifo_rd_en}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_load_tx_high", v), {31'b0, tx}, 32'd1);
      @(negedge clk);
      check_frame(vecs[v].line, $sformatf("v%0d", v), -1);
      chk($sformatf("v%0d_idle_busy", v), {31'b0, busy}, 32'd0);
      chk($sformatf("v%0d_idle_tx", v), {31'b0, tx}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_rd_pulses", v), rd_count - rd0, 32'd1);
      chk($sformatf("v%0d_bd_pulses", v), bd_count - bd0, 32'd1);
      chk($sformatf("v%0d_fifo_empty", v), {31'b0, fifo_empty}, 32'd1);
    end

    // Back-to-back 0x00, 0xFF
    enable = 1'b0;
    rd0 = rd_count;
    bd0 = bd_count;
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    enable = 1'b1;
    wait_start("b2b0");
    check_frame(10'b1_00000000_0, "b2b0", -1);
    check_gap("b2b");
    check_frame(10'b1_11111111_0, "b2b1", -1);
    @(negedge clk);
    chk("b2b_rd_pulses", rd_count - rd0, 32'd2);
    chk("b2b_bd_pulses", bd_count - bd0, 32'd2);
    chk("b2b_fifo_empty", {31'b0, fifo_empty}, 32'd1);
    chk("b2b_idle_busy", {31'b0, busy}, 32'd0);

    // Enable dropped during data bits of the first of three words
    enable = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    @(negedge clk);
    enable = 1'b1;
    wait_start("gate0");
    check_frame(10'b1_00010001_0, "gate0", 10);
    rd0 = rd_count;
    for (int i = 0; i < 30; i++) @(negedge clk);
    chk("gate_no_rd_en", rd_count - rd0, 32'd0);
    chk("gate_idle_busy", {31'b0, busy}, 32'd0);
    chk("gate_fifo_pending", {31'b0, fifo_empty}, 32'd0);
    enable = 1'b1;
    wait_start("gate1");
    check_frame(10'b1_00100010_0, "gate1", -1);
    check_gap("gate");
    check_frame(10'b1_00110011_0, "gate2", -1);
    @(negedge clk);
    chk("gate_fifo_empty", {31'b0, fifo_empty}, 32'd1);

    // Reset during data bit 3 of 0x52 (bit 3 is 0 so the async return high is visible)
    enable = 1'b0;
    push(8'h52);
    push(8'h77);
    @(negedge clk);
    enable = 1'b1;
    wait_start("rstmid");
    for (int i = 0; i < 17; i++) @(negedge clk);
    chk("rstmid_pre_tx", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_async_tx", {31'b0, tx}, 32'd1);
    chk("rstmid_async_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_held_tx", {31'b0, tx}, 32'd1);
    rst = 1'b0;
    wait_start("rstmid_next");
    check_frame(10'b1_01110111_0, "rstmid_next", -1);
    @(negedge clk);
    chk("rstmid_fifo_empty", {31'b0, fifo_empty}, 32'd1);

    // Empty FIFO with enable high, then a late write
    rd0 = rd_count;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0)
        chk($sformatf("empty_idle_c%0d", i), {29'b0, fifo_rd_en, tx, busy}, 32'b010);
    end
    chk("empty_no_rd_en", rd_count - rd0, 32'd0);
    chk("empty_tx_high", {31'b0, tx}, 32'd1);
    push(8'hC3);
    @(negedge clk);
    chk("late_write_fetch", {31'b0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_frame(10'b1_11000011_0, "late", -1);
    @(negedge clk);
    chk("late_rd_pulses", rd_count - rd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the synchronous FIFO. Pops one word at a time through the FIFO read port (rd_en/dout/empty) and serializes it as an asynchronous UART frame: 1 start bit, DSIZE data bits LSB first, 1 stop bit, no parity.
- Sits between the FIFO and the board TX pin.
- Owns the FIFO read handshake, including the FIFO's one-cycle registered dout latency.

Parameters:
- DSIZE, 8, data word width; must match the FIFO's DSIZE.
- CLKS_PER_BIT, 16, clk cycles per UART bit period; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  reset; asynchronous, active-high.
- enable  input  1  permits starting new frames; sampled only at frame boundaries.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read strobe; one cycle per word.
- fifo_dout  input  DSIZE  FIFO read data; valid the cycle after fifo_rd_en.
- tx  output  1  serial line; idles high.
- busy  output  1  high from FETCH through STOP inclusive.
- byte_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (rstn=1, async): state=IDLE, tx=1, fifo_rd_en=0, busy=0, byte_done=0, bit/baud counters=0, shift register=0. Reset mid-frame aborts the frame and tx returns high immediately. A word already popped is lost (accepted).
- States: IDLE, FETCH, LOAD, START, DATA, STOP. Encoding is a typedef enum.
- IDLE: tx=1. If enable && !fifo_empty at a clock edge, go to FETCH.
- FETCH (1 cycle): fifo_rd_en=1, decoded from the state register, glitch-free, exactly one cycle. Go to LOAD.
- LOAD (1 cycle): capture fifo_dout into shift_reg at the end of this cycle. Clear counters. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles. Then go to DATA with bit_idx=0.
- DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit DSIZE-1 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. byte_done=1 on the final cycle. Then:
  - if enable && !fifo_empty, go directly to FETCH (back-to-back);
  - otherwise go to IDLE.
- tx is a registered output. It is driven from the state/shift register, with no combinational path from inputs.
- Latency: if the condition is sampled at edge N, fifo_rd_en is high in cycle N..N+1 and the start bit begins at edge N+2.
- Frame length: exactly (DSIZE+2)*CLKS_PER_BIT cycles of START..STOP. Back-to-back frames have a 2-cycle high gap (FETCH+LOAD) between stop and start.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. bit_idx width: $clog2(DSIZE)+1.
- enable deassertion mid-frame: the current frame completes normally and no further fetch occurs.
- fifo_empty is ignored outside IDLE/STOP-final. A FIFO write arriving mid-frame is picked up at the end of STOP.
- fifo_rd_en is never asserted while fifo_empty=1 at the sampling edge. This means no FIFO underflow reads are issued.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, FETCH, LOAD, START, DATA, STOP);
  - localparam default CLKS_PER_BIT;
  - frame constants START_BIT=1'b0 and STOP_BIT=1'b1.
- Sub-module uart_baud_counter (params CLKS_PER_BIT):
  - inputs clk, rstn, clear;
  - output tick, asserted on count==CLKS_PER_BIT-1.
- The top-level FSM, shift register and bit counter stay in fifo_uart_tx.

Test Plan:
1. Reset values. Assert rstn for 3 cycles mid-idle, then release → tx=1, busy=0, fifo_rd_en=0, byte_done=0 throughout.
2. Single byte. CLKS_PER_BIT=4, FIFO preloaded with 0xA5, enable=1 → exactly one fifo_rd_en pulse. tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). byte_done pulses once on cycle 40. Returns to IDLE with FIFO empty.
3. Back-to-back. FIFO holds 0x00, 0xFF, enable=1 → two frames separated by exactly 2 high cycles. The second frame's data bits are all 1. Two rd_en pulses, two byte_done pulses. FIFO empty at the end.
4. Enable gating. FIFO holds 3 words. Drop enable during the data bits of word 1 → word 1 completes and no further rd_en occurs. Re-raising enable resumes with word 2.
5. Reset mid-frame. Assert rstn during DATA bit 3 → tx=1 asynchronously (before the next clk edge) and state IDLE. After release with FIFO non-empty, the next word is transmitted cleanly from the start bit.
6. Empty FIFO. enable=1, FIFO empty for 100 cycles → fifo_rd_en never asserted, tx=1, busy=0. A write then arrives → fetch begins within 1 cycle of fifo_empty falling.
